// File: rtl/cg_text_renderer_pkg.sv
// Shared definitions for the character-generator text renderer:
// FSM state encoding, glyph geometry, default sizing and the glyph
// strip address helper.
package cg_text_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_FETCH_CODE  = 2'd1,
        ST_FETCH_STRIP = 2'd2,
        ST_SHIFT       = 2'd3
    } state_t;

    localparam int GLYPH_ROWS      = 16;
    localparam int GLYPH_W         = 8;
    localparam int COLS_DEFAULT    = 80;
    localparam int N_CHARS_DEFAULT = 41;

    // Strip address = code*16 + glyph row; codes outside the ROM map to the blank glyph 0.
    function automatic logic [9:0] glyph_addr(input logic [7:0] code,
                                              input logic [3:0] grow,
                                              input int         n_chars);
        logic [7:0] eff;
        eff = (int'(code) >= n_chars) ? 8'd0 : code;
        return ({2'b00, eff} << 4) | {6'd0, grow};
    endfunction

endpackage

// File: rtl/cg_text_renderer_if.sv
// Line-control, memory-fetch and pixel signals of the text renderer.
// Optional cursor signals exist only when CGTXT_CURSOR_EN is defined.
interface cg_text_renderer_if #(
    parameter int TXT_AW = 12
);
    logic              i_line_start;
    logic [8:0]        i_row;
    logic [TXT_AW-1:0] o_txt_addr;
    logic [7:0]        i_txt_code;
    logic [9:0]        o_cgrom_addr;
    logic [7:0]        i_char_strip;
    logic              o_pixel;
    logic              o_pixel_valid;
    logic              o_busy;
`ifdef CGTXT_CURSOR_EN
    logic              i_frame_start;
    logic [TXT_AW-1:0] i_cursor_addr;
`endif

    // Renderer side: issues addresses, consumes codes/strips, produces pixels.
    modport master (
        input  i_line_start, i_row, i_txt_code, i_char_strip,
`ifdef CGTXT_CURSOR_EN
        input  i_frame_start, i_cursor_addr,
`endif
        output o_txt_addr, o_cgrom_addr, o_pixel, o_pixel_valid, o_busy
    );

    // Video timing / memory side.
    modport slave (
        output i_line_start, i_row, i_txt_code, i_char_strip,
`ifdef CGTXT_CURSOR_EN
        output i_frame_start, i_cursor_addr,
`endif
        input  o_txt_addr, o_cgrom_addr, o_pixel, o_pixel_valid, o_busy
    );
endinterface

// File: rtl/cg_text_renderer_shifter.sv
// 8-bit strip load/shift register with its 0..7 bit counter.
// MSB is presented first; a load restarts the bit counter.
module cg_pixel_shifter
    import cg_text_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift_en,
    input  logic [GLYPH_W-1:0] strip,
    output logic         msb,
    output logic [2:0]   bit_cnt
);
    logic [GLYPH_W-1:0] sr;

    // Load a new strip or shift one pixel out per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= strip;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr      <= {sr[GLYPH_W-2:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign msb = sr[GLYPH_W-1];

endmodule

// File: rtl/cg_text_renderer.sv
// Character-generator text renderer: turns one text row of codes into a
// serial pixel stream for one active line, prefetching the next column
// during the last pixels of the current one so columns are gap-free.
// Optional macro CGTXT_CURSOR_EN adds a blinking underline cursor.
//
// state          | meaning
// ---------------+----------------------------------------------------
// ST_IDLE        | no line in progress, outputs quiet
// ST_FETCH_CODE  | text address for column 0 out, code arriving
// ST_FETCH_STRIP | glyph strip address for column 0 out, strip arriving
// ST_SHIFT       | shifting pixels, prefetching the next column
module cg_text_renderer
    import cg_text_pkg::*;
#(
    parameter int COLS    = COLS_DEFAULT,
    parameter int N_CHARS = N_CHARS_DEFAULT,
    parameter int TXT_AW  = 12
) (
    input  logic i_clk,
    input  logic i_rst_n,
    cg_text_renderer_if.master bus
);
    localparam int AW1 = TXT_AW + 1;
    localparam int CW  = $clog2(COLS + 1);

    state_t            state;
    logic [CW-1:0]     col;
    logic [AW1-1:0]    row_base;
    logic [AW1-1:0]    base_q;
    logic [AW1-1:0]    next_addr;
    logic [3:0]        grow_q;
    logic [TXT_AW-1:0] txt_addr_q;
    logic [9:0]        cgrom_addr_q;
    logic              valid_q;
    logic              busy_q;
    logic              last_col;
    logic              load;
    logic              shift_en;
    logic              sr_msb;
    logic [2:0]        bit_cnt;
    logic              pix_valid;
    logic              unused_addr_msb;

    assign row_base        = AW1'(bus.i_row[8:4]) * AW1'(COLS);
    assign next_addr       = base_q + AW1'(col) + AW1'(1);
    assign unused_addr_msb = next_addr[TXT_AW];
    assign last_col        = (col == CW'(COLS - 1));

    // A restart pulse wins over any load that would otherwise happen in the same cycle.
    assign load     = !bus.i_line_start &&
                      ((state == ST_FETCH_STRIP) ||
                       (state == ST_SHIFT && bit_cnt == 3'd7 && !last_col));
    assign shift_en = !bus.i_line_start && (state == ST_SHIFT);

    // Line sequencer: fetch code, fetch strip, then shift with next-column prefetch
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            col          <= '0;
            base_q       <= '0;
            grow_q       <= '0;
            txt_addr_q   <= '0;
            cgrom_addr_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.i_line_start) begin
            state      <= ST_FETCH_CODE;
            base_q     <= row_base;
            grow_q     <= bus.i_row[3:0];
            col        <= '0;
            txt_addr_q <= row_base[TXT_AW-1:0];
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state)
                ST_FETCH_CODE: begin
                    cgrom_addr_q <= glyph_addr(bus.i_txt_code, grow_q, N_CHARS);
                    state        <= ST_FETCH_STRIP;
                end
                ST_FETCH_STRIP: begin
                    state   <= ST_SHIFT;
                    valid_q <= 1'b1;
                end
                ST_SHIFT: begin
                    if (!last_col) begin
                        if (bit_cnt == 3'd5)
                            txt_addr_q <= next_addr[TXT_AW-1:0];
                        if (bit_cnt == 3'd6)
                            cgrom_addr_q <= glyph_addr(bus.i_txt_code, grow_q, N_CHARS);
                        if (bit_cnt == 3'd7)
                            col <= col + CW'(1);
                    end else if (bit_cnt == 3'd7) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    cg_pixel_shifter u_shifter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (load),
        .shift_en (shift_en),
        .strip    (bus.i_char_strip),
        .msb      (sr_msb),
        .bit_cnt  (bit_cnt)
    );

    // An abort pulse blanks the pixel of the line being dropped immediately.
    assign pix_valid         = valid_q & ~bus.i_line_start;
    assign bus.o_pixel_valid = pix_valid;
    assign bus.o_busy        = busy_q;
    assign bus.o_txt_addr    = txt_addr_q;
    assign bus.o_cgrom_addr  = cgrom_addr_q;

`ifdef CGTXT_CURSOR_EN
    logic [4:0]        frame_cnt;
    logic [TXT_AW-1:0] cell_q;
    logic              cursor_hit;

    // Blink timer and text address of the cell currently being shifted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            cell_q    <= '0;
        end else begin
            if (bus.i_frame_start)
                frame_cnt <= frame_cnt + 5'd1;
            if (load)
                cell_q <= (state == ST_FETCH_STRIP) ? base_q[TXT_AW-1:0]
                                                    : next_addr[TXT_AW-1:0];
        end
    end

    assign cursor_hit  = frame_cnt[4] && (grow_q[3:1] == 3'b111) &&
                         (cell_q == bus.i_cursor_addr);
    assign bus.o_pixel = pix_valid & (sr_msb ^ cursor_hit);
`else
    assign bus.o_pixel = pix_valid & sr_msb;
`endif

endmodule

// File: tb/tb_cg_text_renderer.sv
// Bench for cg_text_renderer: random text contents against a line-level
// pixel model, plus restart, reset and (with CGTXT_CURSOR_EN) cursor cases.
module tb_cg_text_renderer;
    localparam int COLS    = 80;
    localparam int N_CHARS = 41;
    localparam int TXT_AW  = 12;
    localparam int NPX     = COLS * 8;
    localparam int CURSOR  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   frames  = 0;

    logic [7:0] txt_mem [0:(1<<TXT_AW)-1];
    bit         exp_px  [NPX];
    bit         act_px  [NPX];
    int         exp_txt [COLS];
    int         exp_cg  [COLS];
    int         cg_seen [COLS];

    cg_text_renderer_if #(.TXT_AW(TXT_AW)) bus ();

    cg_text_renderer #(.COLS(COLS), .N_CHARS(N_CHARS), .TXT_AW(TXT_AW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Glyph ROM model: glyph 0 is blank, everything else a scrambled pattern.
    function automatic logic [7:0] rom_strip(input logic [9:0] a);
        if (a[9:4] == 6'd0) return 8'h00;
        return 8'(int'(a) * 29) ^ 8'(int'(a) >> 3) ^ 8'hA5;
    endfunction

    assign bus.i_txt_code   = txt_mem[bus.o_txt_addr];
    assign bus.i_char_strip = rom_strip(bus.o_cgrom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-line reference: address, code, glyph and pixels per column.
    task automatic build_expected(input logic [8:0] row);
        int trow, grow, addr, code, eff;
        logic [7:0] strip;
        bit inv;
        trow = int'(row[8:4]);
        grow = int'(row[3:0]);
        for (int c = 0; c < COLS; c++) begin
            addr = (trow * COLS + c) % (1 << TXT_AW);
            code = int'(txt_mem[addr]);
            eff  = (code >= N_CHARS) ? 0 : code;
            strip = rom_strip(10'(eff * 16 + grow));
            exp_txt[c] = addr;
            exp_cg[c]  = eff * 16 + grow;
            inv = 1'b0;
`ifdef CGTXT_CURSOR_EN
            inv = ((frames % 32) >= 16) && (grow >= 14) && (addr == CURSOR);
`endif
            for (int b = 0; b < 8; b++)
                exp_px[c*8 + b] = strip[7-b] ^ inv;
        end
    endtask

    task automatic pulse_line(input logic [8:0] row);
        @(negedge clk);
        bus.i_row        = row;
        bus.i_line_start = 1'b1;
        @(negedge clk);
        bus.i_line_start = 1'b0;
    endtask

    // Start one line and follow it to completion against the model.
    task automatic run_line(input logic [8:0] row, input string tag);
        int first, nvalid, px_err, addr_err, gap, c;
        first = -1; nvalid = 0; px_err = 0; addr_err = 0; gap = 0;
        build_expected(row);
        @(negedge clk);
        bus.i_row        = row;
        bus.i_line_start = 1'b1;
        #1 chk({tag, "_valid_on_start"}, 32'(bus.o_pixel_valid), 32'd0);
        @(negedge clk);
        bus.i_line_start = 1'b0;
        for (int k = 1; k < 700; k++) begin
            if (k == 1) begin
                chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
                chk({tag, "_txt_addr0"}, 32'(bus.o_txt_addr), 32'(exp_txt[0]));
            end
            if (k == 2)
                chk({tag, "_cgrom_addr0"}, 32'(bus.o_cgrom_addr), 32'(exp_cg[0]));
            if ((k - 1) % 8 == 0 && (k - 1) / 8 < COLS) begin
                c = (k - 1) / 8;
                if (int'(bus.o_txt_addr) != exp_txt[c]) addr_err++;
            end
            if ((k - 2) % 8 == 0 && (k - 2) / 8 < COLS) begin
                c = (k - 2) / 8;
                cg_seen[c] = int'(bus.o_cgrom_addr);
                if (cg_seen[c] != exp_cg[c]) addr_err++;
            end
            if (bus.o_pixel_valid === 1'b1) begin
                if (first < 0) first = k;
                else if (k != first + nvalid) gap++;
                if (nvalid < NPX) begin
                    act_px[nvalid] = bus.o_pixel;
                    if (bus.o_pixel !== exp_px[nvalid]) px_err++;
                end
                nvalid++;
            end else if (bus.o_pixel !== 1'b0) begin
                px_err++;
            end
            @(negedge clk);
        end
        chk({tag, "_first_px_latency"}, 32'(first), 32'd3);
        chk({tag, "_valid_count"}, 32'(nvalid), 32'(NPX));
        chk({tag, "_valid_gaps"}, 32'(gap), 32'd0);
        chk({tag, "_pixel_errs"}, 32'(px_err), 32'd0);
        chk({tag, "_addr_errs"}, 32'(addr_err), 32'd0);
        chk({tag, "_busy_after"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_valid_after"}, 32'(bus.o_pixel_valid), 32'd0);
    endtask

`ifdef CGTXT_CURSOR_EN
    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_frame_start = 1'b1;
            @(negedge clk);
            bus.i_frame_start = 1'b0;
            frames++;
        end
    endtask
`endif

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_pixel"}, 32'(bus.o_pixel), 32'd0);
        chk({tag, "_valid"}, 32'(bus.o_pixel_valid), 32'd0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_txt_addr"}, 32'(bus.o_txt_addr), 32'd0);
        chk({tag, "_cgrom_addr"}, 32'(bus.o_cgrom_addr), 32'd0);
    endtask

    initial begin
        int ones;
        logic [8:0] row;
        bus.i_line_start = 1'b0;
        bus.i_row        = '0;
`ifdef CGTXT_CURSOR_EN
        bus.i_frame_start = 1'b0;
        bus.i_cursor_addr = TXT_AW'(CURSOR);
`endif
        for (int a = 0; a < (1 << TXT_AW); a++) txt_mem[a] = 8'($urandom);

        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Codes 0..79 across text row 0
        for (int c = 0; c < COLS; c++) txt_mem[c] = 8'(c);
        run_line(9'h000, "row0_seq");

        // Code 5 at address 160, text row 2, glyph row 3
        txt_mem[160] = 8'd5;
        run_line(9'h023, "row2_code5");
        chk("row2_code5_txt160", 32'(exp_txt[0]), 32'd160);
        chk("row2_code5_cg83", 32'(cg_seen[0]), 32'd83);

        // Out-of-range code in column 3 maps to the blank glyph
        txt_mem[4*COLS + 3] = 8'hFF;
        run_line({5'd4, 4'd7}, "blank_ff");
        chk("blank_ff_cgrom", 32'(cg_seen[3]), 32'd7);
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(act_px[3*8 + b]);
        chk("blank_ff_pixels", 32'(ones), 32'd0);

        // Random rows with random contents
        for (int i = 0; i < 5; i++) begin
            row = 9'($urandom_range(0, 511));
            for (int c = 0; c < COLS; c++)
                txt_mem[int'(row[8:4]) * COLS + c] =
                    ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, N_CHARS - 1));
            run_line(row, $sformatf("rand%0d", i));
        end

        // Restart at column 40 of a running line
        pulse_line({5'd7, 4'd2});
        repeat (322) @(negedge clk);
        chk("abort_pre_valid", 32'(bus.o_pixel_valid), 32'd1);
        chk("abort_pre_txt", 32'(bus.o_txt_addr), 32'(7 * COLS + 40));
        run_line({5'd9, 4'd11}, "abort");

        // Asynchronous reset in the middle of shifting
        pulse_line({5'd12, 4'd5});
        repeat (100) @(negedge clk);
        chk("rst_mid_pre_valid", 32'(bus.o_pixel_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle_busy", 32'(bus.o_busy), 32'd0);
        run_line({5'd12, 4'd5}, "after_rst");

`ifdef CGTXT_CURSOR_EN
        for (int c = 0; c < COLS; c++) txt_mem[c] = 8'($urandom_range(1, N_CHARS - 1));
        frame_pulses(16);
        run_line({5'd0, 4'd14}, "cursor_on");
        run_line({5'd0, 4'd13}, "cursor_row13");
        frame_pulses(16);
        run_line({5'd0, 4'd14}, "cursor_off");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
